// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle datapath: opcodes, FSM states,
// ALU/PC mux selects and the per-state control word.
package multicycle_controller_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_BRANCH = 4'd11,
        ST_JUMP   = 4'd12,
        ST_HALT   = 4'd13
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       halted;
        logic       in_decode;
    } ctrl_t;

    // Control word asserted while the FSM sits in a given state.
    function automatic ctrl_t ctrl_of(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.irwrite = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.aluop   = ALUOP_ADD;
                c.pcsrc   = PCSRC_ALU;
                c.pcwrite = 1'b1;
            end
            ST_DECODE: begin
                c.alusrcb   = SRCB_IMM_SH2;
                c.aluop     = ALUOP_ADD;
                c.in_decode = 1'b1;
            end
            ST_MEMADR, ST_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            ST_MEMRD: c.iord = 1'b1;
            ST_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            ST_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            ST_EXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REGB;
                c.aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            ST_ADDIWB: c.regwrite = 1'b1;
            ST_BRANCH: begin
                c.pcsrc  = PCSRC_ALUOUT;
                c.branch = 1'b1;
            end
            ST_JUMP: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            ST_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // True for every opcode the controller knows how to sequence.
    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle datapath. Moore machine whose control
// word is registered from the next state, so every enable is glitch-free and
// cleared directly by the asynchronous reset. Only pcen (branch qualified by
// eq) and illegal (opcode check in DECODE) carry a combinational term.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op,
    input  logic             eq,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_r;
    state_t           state_n_s;
    ctrl_t            ctrl_r;
    logic [CNT_W-1:0] count_r;
    logic             retire_s;

    // Next-state selection; op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE:   state_n_s = ST_FETCH;
            ST_FETCH:  state_n_s = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW:   state_n_s = ST_MEMADR;
                    OP_ADD, OP_SUB: state_n_s = ST_EXEC;
                    OP_ADDI:        state_n_s = ST_ADDIEX;
                    OP_BEQ:         state_n_s = ST_BRANCH;
                    OP_J:           state_n_s = ST_JUMP;
                    OP_HALT:        state_n_s = ST_HALT;
                    default:        state_n_s = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                if (op == OP_SW) begin
                    state_n_s = ST_MEMWR;
                end else begin
                    state_n_s = ST_MEMRD;
                end
            end
            ST_MEMRD:  state_n_s = ST_MEMWB;
            ST_EXEC:   state_n_s = ST_ALUWB;
            ST_ADDIEX: state_n_s = ST_ADDIWB;
            ST_MEMWB, ST_MEMWR, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP:
                       state_n_s = ST_FETCH;
            ST_HALT:   state_n_s = ST_HALT;
            default:   state_n_s = ST_IDLE;
        endcase
    end

    // An instruction retires on the edge that leaves its last state for FETCH.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            ST_MEMWB, ST_MEMWR, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: retire_s = 1'b1;
            default: retire_s = 1'b0;
        endcase
    end

    // State register plus control word decoded ahead from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_n_s;
            ctrl_r  <= ctrl_of(state_n_s);
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (retire_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign iord        = ctrl_r.iord;
    assign memwrite    = ctrl_r.memwrite;
    assign irwrite     = ctrl_r.irwrite;
    assign regwrite    = ctrl_r.regwrite;
    assign regdst      = ctrl_r.regdst;
    assign memtoreg    = ctrl_r.memtoreg;
    assign alusrca     = ctrl_r.alusrca;
    assign alusrcb     = ctrl_r.alusrcb;
    assign aluop       = ctrl_r.aluop;
    assign pcsrc       = ctrl_r.pcsrc;
    assign pcen        = ctrl_r.pcwrite | (ctrl_r.branch & eq);
    assign illegal     = ctrl_r.in_decode & ~op_legal(op);
    assign halted      = ctrl_r.halted;
    assign instr_count = count_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each scenario pushes the
// expected per-cycle outputs and count, then pops and compares one entry per
// clock, sampling on the falling edge.
module tb_multicycle_controller;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                   S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_ALUWB = 8, S_ADDIEX = 9,
                   S_ADDIWB = 10, S_BRANCH = 11, S_JUMP = 12, S_HALT = 13;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
        logic       halted;
    } outs_t;

    typedef struct packed {
        outs_t       v;
        logic [15:0] c;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  op;
    logic        eq;
    logic        iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0]  alusrcb, aluop, pcsrc;
    logic        pcen, illegal, halted;
    logic [15:0] instr_count;

    logic        rst_w_n;
    logic [3:0]  op_w;
    logic        eq_w;
    logic        iord_w, memwrite_w, irwrite_w, regwrite_w, regdst_w, memtoreg_w, alusrca_w;
    logic [1:0]  alusrcb_w, aluop_w, pcsrc_w;
    logic        pcen_w, illegal_w, halted_w;
    logic [3:0]  instr_count_w;

    outs_t obs, obs_w;
    sb_t   sb_q[$];
    sb_t   ent;
    logic [15:0] model_cnt;
    int    checks;
    int    failures;

    assign obs   = {iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                    alusrcb, aluop, pcsrc, pcen, illegal, halted};
    assign obs_w = {iord_w, memwrite_w, irwrite_w, regwrite_w, regdst_w, memtoreg_w, alusrca_w,
                    alusrcb_w, aluop_w, pcsrc_w, pcen_w, illegal_w, halted_w};

    multicycle_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .eq(eq),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal),
        .halted(halted), .instr_count(instr_count)
    );

    multicycle_controller #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_w_n), .op(op_w), .eq(eq_w),
        .iord(iord_w), .memwrite(memwrite_w), .irwrite(irwrite_w), .regwrite(regwrite_w),
        .regdst(regdst_w), .memtoreg(memtoreg_w), .alusrca(alusrca_w), .alusrcb(alusrcb_w),
        .aluop(aluop_w), .pcsrc(pcsrc_w), .pcen(pcen_w), .illegal(illegal_w),
        .halted(halted_w), .instr_count(instr_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a state, written straight from the control table.
    function automatic outs_t exp_of(input int st, input logic e, input logic ill);
        outs_t o;
        o = '0;
        case (st)
            S_FETCH:  begin o.irwrite = 1'b1; o.alusrcb = 2'b01; o.pcen = 1'b1; end
            S_DECODE: begin o.alusrcb = 2'b11; o.illegal = ill; end
            S_MEMADR: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            S_MEMRD:  o.iord = 1'b1;
            S_MEMWB:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
            S_MEMWR:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
            S_EXEC:   begin o.alusrca = 1'b1; o.alusrcb = 2'b00; o.aluop = 2'b10; end
            S_ALUWB:  begin o.regwrite = 1'b1; o.regdst = 1'b1; end
            S_ADDIEX: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            S_ADDIWB: o.regwrite = 1'b1;
            S_BRANCH: begin o.pcsrc = 2'b01; o.pcen = e; end
            S_JUMP:   begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
            S_HALT:   o.halted = 1'b1;
            default:  o = '0;
        endcase
        return o;
    endfunction

    // Queue one expected cycle; a retiring state bumps the count seen afterwards.
    task automatic push(input int st, input logic ill);
        sb_q.push_back({exp_of(st, eq, ill), model_cnt});
        if (st == S_MEMWB || st == S_MEMWR || st == S_ALUWB || st == S_ADDIWB ||
            st == S_BRANCH || st == S_JUMP) begin
            model_cnt = model_cnt + 16'd1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op = 4'b0000; eq = 1'b0; model_cnt = 16'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== outs_t'(0) || instr_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_hold: outs=%h cnt=%0d, expected outs=0 cnt=0", obs, instr_count);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== outs_t'(0) || instr_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_idle: outs=%h cnt=%0d, expected outs=0 cnt=0", obs, instr_count);
        end
    endtask

    task automatic test_alu;
        op = 4'b0000;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b0); push(S_EXEC, 1'b0); push(S_ALUWB, 1'b0);
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL add: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
        op = 4'b0010;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b0); push(S_EXEC, 1'b0); push(S_ALUWB, 1'b0);
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL sub: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
    endtask

    task automatic test_mem;
        op = 4'b0100;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b0); push(S_MEMADR, 1'b0);
        push(S_MEMRD, 1'b0); push(S_MEMWB, 1'b0);
        op = 4'b0100;
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL lw: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
        op = 4'b0101;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b0); push(S_MEMADR, 1'b0); push(S_MEMWR, 1'b0);
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL sw: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
    endtask

    task automatic test_addi;
        op = 4'b0111;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b0); push(S_ADDIEX, 1'b0); push(S_ADDIWB, 1'b0);
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL addi: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
    endtask

    task automatic test_branch;
        for (int k = 0; k < 2; k++) begin
            op = 4'b0110;
            eq = (k == 0) ? 1'b1 : 1'b0;
            push(S_FETCH, 1'b0); push(S_DECODE, 1'b0); push(S_BRANCH, 1'b0);
            while (sb_q.size() != 0) begin
                @(negedge clk);
                ent = sb_q.pop_front();
                checks++;
                if (obs !== ent.v || instr_count !== ent.c) begin
                    failures++;
                    $display("FAIL beq_eq%0d: outs=%h cnt=%0d, expected outs=%h cnt=%0d",
                             eq, obs, instr_count, ent.v, ent.c);
                end
            end
        end
        eq = 1'b0;
    endtask

    task automatic test_jump;
        op = 4'b1000;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b0); push(S_JUMP, 1'b0);
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL jump: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
    endtask

    task automatic test_illegal;
        op = 4'b1011;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b1);
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL illegal: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
        // hold op through the DECODE exit edge before the next scenario drives it
        @(posedge clk);
        #1;
    endtask

    task automatic test_halt;
        op = 4'b1111;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b0);
        for (int k = 0; k < 20; k++) push(S_HALT, 1'b0);
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL halt: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== outs_t'(0) || instr_count !== 16'd0) begin
            failures++;
            $display("FAIL halt_reset: outs=%h cnt=%0d, expected outs=0 cnt=0", obs, instr_count);
        end
        model_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== outs_t'(0) || instr_count !== 16'd0) begin
            failures++;
            $display("FAIL halt_idle: outs=%h cnt=%0d, expected outs=0 cnt=0", obs, instr_count);
        end
    endtask

    task automatic test_reset_in_memwr;
        op = 4'b0000;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b0); push(S_EXEC, 1'b0); push(S_ALUWB, 1'b0);
        op = 4'b0000;
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL pre_memwr: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
        op = 4'b0101;
        push(S_FETCH, 1'b0); push(S_DECODE, 1'b0); push(S_MEMADR, 1'b0); push(S_MEMWR, 1'b0);
        while (sb_q.size() != 0) begin
            @(negedge clk);
            ent = sb_q.pop_front();
            checks++;
            if (obs !== ent.v || instr_count !== ent.c) begin
                failures++;
                $display("FAIL memwr: outs=%h cnt=%0d, expected outs=%h cnt=%0d", obs, instr_count, ent.v, ent.c);
            end
        end
        // mid-cycle, well before the next rising edge
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (memwrite !== 1'b0 || obs !== outs_t'(0) || instr_count !== 16'd0) begin
            failures++;
            $display("FAIL memwr_abort: memwrite=%b outs=%h cnt=%0d, expected memwrite=0 outs=0 cnt=0",
                     memwrite, obs, instr_count);
        end
    endtask

    task automatic test_count_wrap;
        op_w = 4'b1000; eq_w = 1'b0;
        @(negedge clk);
        rst_w_n = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (obs_w !== exp_of(S_FETCH, 1'b0, 1'b0) || instr_count_w !== 4'(k % 16)) begin
                failures++;
                $display("FAIL wrap_fetch%0d: outs=%h cnt=%0d, expected outs=%h cnt=%0d",
                         k, obs_w, instr_count_w, exp_of(S_FETCH, 1'b0, 1'b0), k % 16);
            end
            if (k < 16) begin
                @(negedge clk);
                @(negedge clk);
                checks++;
                if (obs_w !== exp_of(S_JUMP, 1'b0, 1'b0)) begin
                    failures++;
                    $display("FAIL wrap_jump%0d: outs=%h, expected outs=%h",
                             k, obs_w, exp_of(S_JUMP, 1'b0, 1'b0));
                end
            end
        end
    endtask

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0;
        rst_w_n = 1'b0; op_w = 4'b0000; eq_w = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_addi();
        test_branch();
        test_jump();
        test_illegal();
        test_halt();
        test_reset_in_memwr();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
